game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl.sv | 139 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer for the VGA platformer. It owns the menu/play/dying/lose/win
// state, the lives and seconds counters, and the respawn and freeze hand-off to the character logic.
module game_flow_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int TIME_LIMIT     = 60,
    parameter int FRAMES_PER_SEC = 60,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       in_lava,
    input  logic       at_goal,
    output logic [2:0] S,
    output logic [2:0] lives,
    output logic [6:0] time_left,
    output logic       respawn,
    output logic       freeze,
    output logic       game_run
);

    typedef enum logic [2:0] {
        ST_MENU  = 3'b000,
        ST_PLAY  = 3'b001,
        ST_LOSE  = 3'b010,
        ST_WIN   = 3'b011,
        ST_DYING = 3'b100
    } state_t;

    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [6:0] TIME_LOAD  = 7'(TIME_LIMIT);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] DIE_LOAD   = 8'(RESPAWN_FRAMES);

    state_t     state;
    logic [7:0] frame_cnt;
    logic [7:0] die_cnt;
    logic       grace;
    logic       start_q;
    logic       start_rise;

    assign start_rise = start_btn & ~start_q;
    assign S          = state;

    // freeze and game_run are written together with every state change,
    // so they always describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_MENU;
            lives     <= LIVES_LOAD;
            time_left <= TIME_LOAD;
            respawn   <= 1'b0;
            freeze    <= 1'b1;
            game_run  <= 1'b0;
            frame_cnt <= 8'd0;
            die_cnt   <= 8'd0;
            grace     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= start_btn;
            respawn <= 1'b0;

            case (state)
                ST_MENU, ST_LOSE: begin
                    if (start_rise) begin
                        lives     <= LIVES_LOAD;
                        time_left <= TIME_LOAD;
                        frame_cnt <= 8'd0;
                        grace     <= 1'b1;
                        respawn   <= 1'b1;
                        state     <= ST_PLAY;
                        freeze    <= 1'b0;
                        game_run  <= 1'b1;
                    end
                end

                // Goal beats lava, and both swallow a coincident frame tick.
                ST_PLAY: begin
                    if (at_goal) begin
                        state    <= ST_WIN;
                        freeze   <= 1'b1;
                        game_run <= 1'b0;
                    end else if (in_lava && !grace) begin
                        lives    <= lives - 3'd1;
                        freeze   <= 1'b1;
                        game_run <= 1'b0;
                        if (lives == 3'd1) begin
                            state <= ST_LOSE;
                        end else begin
                            state   <= ST_DYING;
                            die_cnt <= DIE_LOAD;
                        end
                    end else if (frame_tick) begin
                        grace <= 1'b0;
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= 8'd0;
                            time_left <= time_left - 7'd1;
                            if (time_left == 7'd1) begin
                                state    <= ST_LOSE;
                                freeze   <= 1'b1;
                                game_run <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                // The timer stays paused here; only the death animation counts down.
                ST_DYING: begin
                    if (frame_tick) begin
                        die_cnt <= die_cnt - 8'd1;
                        if (die_cnt == 8'd1) begin
                            state    <= ST_PLAY;
                            respawn  <= 1'b1;
                            grace    <= 1'b1;
                            freeze   <= 1'b0;
                            game_run <= 1'b1;
                        end
                    end
                end

                ST_WIN: begin
                    if (start_rise) begin
                        state <= ST_MENU;
                    end
                end

                default: begin
                    state    <= ST_MENU;
                    freeze   <= 1'b1;
                    game_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed scenarios followed by random play.
// Each cycle the outputs are compared against a frame-counting reference model.
module tb_game_flow_ctrl;

    localparam int LI  = 2;
    localparam int TL  = 3;
    localparam int FPS = 4;
    localparam int RF  = 2;

    localparam int M_MENU  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_LOSE  = 2;
    localparam int M_WIN   = 3;
    localparam int M_DYING = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       in_lava = 1'b0;
    logic       at_goal = 1'b0;
    logic [2:0] S;
    logic [2:0] lives;
    logic [6:0] time_left;
    logic       respawn;
    logic       freeze;
    logic       game_run;

    int checks = 0;
    int errors = 0;

    // The reference model tracks elapsed frames per attempt instead of a seconds/frames pair.
    int  m_mode       = M_MENU;
    int  m_lives      = LI;
    int  m_elapsed    = 0;
    int  m_dying_left = 0;
    bit  m_grace      = 1'b0;
    bit  m_start_prev = 1'b0;
    bit  m_respawn    = 1'b0;

    game_flow_ctrl #(
        .LIVES_INIT    (LI),
        .TIME_LIMIT    (TL),
        .FRAMES_PER_SEC(FPS),
        .RESPAWN_FRAMES(RF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start_btn (start_btn),
        .in_lava   (in_lava),
        .at_goal   (at_goal),
        .S         (S),
        .lives     (lives),
        .time_left (time_left),
        .respawn   (respawn),
        .freeze    (freeze),
        .game_run  (game_run)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic fullLoad();
        m_lives   = LI;
        m_elapsed = 0;
        m_grace   = 1'b1;
        m_respawn = 1'b1;
        m_mode    = M_PLAY;
    endtask

    task automatic modelStep(input bit r, input bit t, input bit s, input bit l, input bit g);
        bit rise;
        if (r) begin
            m_mode = M_MENU; m_lives = LI; m_elapsed = 0; m_dying_left = 0;
            m_grace = 1'b0; m_start_prev = 1'b0; m_respawn = 1'b0;
            return;
        end
        rise = s && !m_start_prev;
        m_start_prev = s;
        m_respawn = 1'b0;
        case (m_mode)
            M_MENU, M_LOSE: if (rise) fullLoad();
            M_PLAY: begin
                if (g) begin
                    m_mode = M_WIN;
                end else if (l && !m_grace) begin
                    m_lives--;
                    if (m_lives == 0) m_mode = M_LOSE;
                    else begin
                        m_mode = M_DYING;
                        m_dying_left = RF;
                    end
                end else if (t) begin
                    m_grace = 1'b0;
                    m_elapsed++;
                    if (m_elapsed == TL * FPS) m_mode = M_LOSE;
                end
            end
            M_DYING: if (t) begin
                m_dying_left--;
                if (m_dying_left == 0) begin
                    m_mode = M_PLAY;
                    m_respawn = 1'b1;
                    m_grace = 1'b1;
                end
            end
            M_WIN: if (rise) m_mode = M_MENU;
            default: m_mode = M_MENU;
        endcase
    endtask

    task automatic applyStimulus(input bit r, input bit t, input bit s, input bit l, input bit g);
        @(negedge clk);
        rst = r; frame_tick = t; start_btn = s; in_lava = l; at_goal = g;
        @(posedge clk);
        modelStep(r, t, s, l, g);
        #1;
        checkOutput("S", int'(S), m_mode);
        checkOutput("lives", int'(lives), m_lives);
        checkOutput("time_left", int'(time_left), TL - m_elapsed / FPS);
        checkOutput("respawn", int'(respawn), int'(m_respawn));
        checkOutput("freeze", int'(freeze), (m_mode != M_PLAY) ? 1 : 0);
        checkOutput("game_run", int'(game_run), (m_mode == M_PLAY) ? 1 : 0);
    endtask

    initial begin
        int pulses;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_S", int'(S), 0);
        checkOutput("rst_freeze", int'(freeze), 1);

        $display("[TB] scenario 1: held start button");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            pulses += int'(respawn);
            if (i == 0) begin
                checkOutput("s1_S", int'(S), 1);
                checkOutput("s1_lives", int'(lives), 2);
                checkOutput("s1_time", int'(time_left), 3);
                checkOutput("s1_game_run", int'(game_run), 1);
            end
        end
        checkOutput("s1_respawn_count", pulses, 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] scenario 2: timer runs out");
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            if (i % 4 == 0) checkOutput("s2_time", int'(time_left), 3 - i / 4);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("s2_S", int'(S), 2);
        checkOutput("s2_freeze", int'(freeze), 1);

        $display("[TB] scenario 3: lava and respawn");
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s3_lives", int'(lives), 1);
        checkOutput("s3_S_dying", int'(S), 4);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s3_S_play", int'(S), 1);
        checkOutput("s3_respawn", int'(respawn), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s3_grace_lives", int'(lives), 1);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s3_grace_tick_lives", int'(lives), 1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] scenario 4: last life");
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("s4_lives", int'(lives), 0);
        checkOutput("s4_S", int'(S), 2);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("s4_retry_S", int'(S), 1);
        checkOutput("s4_retry_lives", int'(lives), 2);
        checkOutput("s4_retry_time", int'(time_left), 3);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] scenario 5: goal priority");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("s5_S", int'(S), 3);
        checkOutput("s5_lives", int'(lives), 2);
        checkOutput("s5_time", int'(time_left), 3);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("s5_menu", int'(S), 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] scenario 6: reset during dying");
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("s6_dying", int'(S), 4);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("s6_S", int'(S), 0);
        checkOutput("s6_respawn", int'(respawn), 0);
        checkOutput("s6_lives", int'(lives), 2);
        checkOutput("s6_time", int'(time_left), 3);

        $display("[TB] random play");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(499, 0) == 0,
                          $urandom_range(2, 0) == 0,
                          $urandom_range(7, 0) == 0,
                          $urandom_range(9, 0) == 0,
                          $urandom_range(39, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
